// File: rtl/rv32_alu_arbiter.sv
// rv32_alu_arbiter: two-requester arbiter sharing one combinational ALU (IDLE/EXEC/RESP).
// Define RV32_ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module rv32_alu_arbiter #(
  parameter bit ISOLATE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opsel,
  input  logic [31:0] req0_s1,
  input  logic [31:0] req0_s2,
  input  logic [31:0] req0_pc,
  input  logic [31:0] req0_code,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opsel,
  input  logic [31:0] req1_s1,
  input  logic [31:0] req1_s2,
  input  logic [31:0] req1_pc,
  input  logic [31:0] req1_code,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] alu_reg_s1,
  output logic [31:0] alu_reg_s2,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_code_bus,
  output logic [3:0]  alu_opsel,
  output logic        alu_enable,
  input  logic [31:0] alu_reg_d1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic owner, hold, g0, g1, accept, rsp_done, iso;
  logic [3:0] opsel_q;
  logic [31:0] s1_q, s2_q, pc_q, code_q, res_q;
`ifndef RV32_ALU_ARB_FIXED_PRIO_EN
  logic last;
`endif
  always_comb begin
`ifdef RV32_ALU_ARB_FIXED_PRIO_EN
    g0 = req0_valid;
`else
    g0 = req0_valid & (~req1_valid | last);
`endif
    g1 = req1_valid & ~g0;
    // hold blocks the first IDLE cycle after a response so a requester cannot re-grab immediately
    req0_ready = rst_n & (state == IDLE) & ~hold & g0;
    req1_ready = rst_n & (state == IDLE) & ~hold & g1;
    accept = req0_ready | req1_ready;
    rsp_done = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);
    state_nx = (state == EXEC) ? RESP : rsp_done ? IDLE : ((state == IDLE) & accept) ? EXEC : state;
    rsp0_valid = (state == RESP) & ~owner;
    rsp1_valid = (state == RESP) & owner;
    rsp0_data = rsp0_valid ? res_q : '0;
    rsp1_data = rsp1_valid ? res_q : '0;
    alu_enable = state == EXEC;
    iso = ISOLATE & (state != EXEC);
    alu_reg_s1 = iso ? '0 : s1_q;
    alu_reg_s2 = iso ? '0 : s2_q;
    alu_pc = iso ? '0 : pc_q;
    alu_code_bus = iso ? '0 : code_q;
    alu_opsel = iso ? '0 : opsel_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      hold <= 1'b0;
      opsel_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      pc_q <= '0;
      code_q <= '0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      hold <= rsp_done;
      if (accept) begin
        owner <= req1_ready;
        opsel_q <= req1_ready ? req1_opsel : req0_opsel;
        s1_q <= req1_ready ? req1_s1 : req0_s1;
        s2_q <= req1_ready ? req1_s2 : req0_s2;
        pc_q <= req1_ready ? req1_pc : req0_pc;
        code_q <= req1_ready ? req1_code : req0_code;
      end
      if (state == EXEC) res_q <= alu_reg_d1;
    end
`ifndef RV32_ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (accept) last <= req1_ready;
`endif
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// tb_rv32_alu_arbiter: scoreboard bench for rv32_alu_arbiter with a behavioural ALU.
module tb_rv32_alu_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable;
  logic [3:0] req0_opsel = 0, req1_opsel = 0, alu_opsel;
  logic [31:0] req0_s1 = 0, req0_s2 = 0, req0_pc = 0, req0_code = 0;
  logic [31:0] req1_s1 = 0, req1_s2 = 0, req1_pc = 0, req1_code = 0;
  logic [31:0] rsp0_data, rsp1_data, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus, alu_reg_d1;
  int total = 0, bad = 0, en_cnt = 0;
  typedef struct { bit id; logic [31:0] d; } item_t;
  item_t q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, b, p, c);
    return op == 0 ? a + b : op == 1 ? a - b : op == 14 ? c : a ^ b ^ p;
  endfunction
  assign alu_reg_d1 = model(alu_opsel, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus);
  rv32_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opsel(req0_opsel),
    .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_pc(req0_pc), .req0_code(req0_code),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opsel(req1_opsel),
    .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_pc(req1_pc), .req1_code(req1_code),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_reg_s1(alu_reg_s1), .alu_reg_s2(alu_reg_s2), .alu_pc(alu_pc),
    .alu_code_bus(alu_code_bus), .alu_opsel(alu_opsel), .alu_enable(alu_enable),
    .alu_reg_d1(alu_reg_d1)
  );
  always @(negedge clk) if (rst_n) begin
    item_t it;
    if (alu_enable) en_cnt++;
    total++;
    if (req0_ready && req1_ready) begin bad++; $display("FAIL both_ready: got 1,1 want at most one"); end
    if (req0_valid && req0_ready) q.push_back('{1'b0, model(req0_opsel, req0_s1, req0_s2, req0_pc, req0_code)});
    if (req1_valid && req1_ready) q.push_back('{1'b1, model(req1_opsel, req1_s1, req1_s2, req1_pc, req1_code)});
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
      total++;
      if (q.size() == 0) begin bad++; $display("FAIL sb_empty: unexpected response rsp0=%0b rsp1=%0b", rsp0_valid, rsp1_valid); end
      else begin
        it = q.pop_front();
        if (it.id !== rsp1_valid || (rsp1_valid ? rsp1_data : rsp0_data) !== it.d) begin
          bad++;
          $display("FAIL sb_data: got id=%0b data=%h want id=%0b data=%h", rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data, it.id, it.d);
        end
      end
    end
    if (rsp0_valid || rsp1_valid) begin
      total++;
      if ((rsp0_valid ? {rsp1_valid, rsp1_data} : {rsp0_valid, rsp0_data}) !== 33'd0) begin
        bad++; $display("FAIL non_owner: rsp0=%0b/%h rsp1=%0b/%h", rsp0_valid, rsp0_data, rsp1_valid, rsp1_data);
      end
    end
  end
  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    q.delete();
  endtask
  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a, b, p, c);
    bit ok = 0;
    @(posedge clk); #1;
    if (id) begin req1_opsel = op; req1_s1 = a; req1_s2 = b; req1_pc = p; req1_code = c; req1_valid = 1; end
    else begin req0_opsel = op; req0_s1 = a; req0_s2 = b; req0_pc = p; req0_code = c; req0_valid = 1; end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL accept_timeout: req%0d ready never seen", id); end
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask
  task automatic test_reset;
    @(posedge clk); #1;
    rst_n = 0; req0_valid = 1; req1_valid = 1;
    #2;
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable, rsp0_data, rsp1_data, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus, alu_opsel} !== '0) begin
      bad++; $display("FAIL reset_outputs: ready=%0b%0b rsp=%0b%0b en=%0b", req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable);
    end
    req0_valid = 0; req1_valid = 0;
    do_reset;
  endtask
  task automatic test_single;
    int e0;
    do_reset;
    e0 = en_cnt;
    issue(0, 4'd0, 32'd5, 32'd7, 32'h100, 32'h33);
    @(negedge clk);
    total++;
    if (alu_enable !== 1 || alu_reg_s1 !== 5 || alu_reg_s2 !== 7 || alu_opsel !== 0) begin
      bad++; $display("FAIL exec_drive: en=%0b s1=%0d s2=%0d op=%0d want 1,5,7,0", alu_enable, alu_reg_s1, alu_reg_s2, alu_opsel);
    end
    @(negedge clk);
    total++;
    if (rsp0_valid !== 1 || rsp0_data !== 12 || rsp1_valid !== 0) begin
      bad++; $display("FAIL single_rsp: v0=%0b d0=%0d v1=%0b want 1,12,0", rsp0_valid, rsp0_data, rsp1_valid);
    end
    total++;
    if (alu_enable !== 0 || alu_reg_s1 !== 0 || alu_reg_s2 !== 0) begin
      bad++; $display("FAIL resp_isolate: en=%0b s1=%0d s2=%0d want 0", alu_enable, alu_reg_s1, alu_reg_s2);
    end
    repeat (4) @(posedge clk);
    total++;
    if (en_cnt - e0 !== 1) begin bad++; $display("FAIL enable_pulses: got %0d want 1", en_cnt - e0); end
  endtask
  task automatic test_round_robin;
    bit ord[4];
    int n = 0;
    do_reset;
    @(posedge clk); #1;
    req0_opsel = 1; req0_s1 = 40; req0_s2 = 15; req0_valid = 1;
    req1_opsel = 2; req1_s1 = 32'hf0; req1_s2 = 32'h0f; req1_pc = 32'h1; req1_valid = 1;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (req0_ready) ord[n++] = 0;
      else if (req1_ready) ord[n++] = 1;
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    total++;
    if (n != 4) begin bad++; $display("FAIL rr_count: got %0d grants want 4", n); end
    for (int i = 0; i < 4; i++) begin
      bit w;
`ifdef RV32_ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = i[0];
`endif
      total++;
      if (ord[i] !== w) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ord[i], w); end
    end
    repeat (6) @(posedge clk);
  endtask
  task automatic test_back_pressure;
    do_reset;
    rsp0_ready = 0;
    req1_opsel = 1; req1_s1 = 50; req1_s2 = 8; req1_pc = 0; req1_code = 0; req1_valid = 1;
    issue(0, 4'd0, 32'd3, 32'd4, 32'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1 || rsp0_data !== 7 || req1_ready !== 0) begin
        bad++; $display("FAIL hold[%0d]: v0=%0b d0=%0d r1=%0b want 1,7,0", i, rsp0_valid, rsp0_data, req1_ready);
      end
    end
    @(posedge clk); #1 rsp0_ready = 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (req1_ready !== 0 || rsp0_valid !== 0) begin
      bad++; $display("FAIL handoff: r1=%0b v0=%0b want 0,0", req1_ready, rsp0_valid);
    end
    @(negedge clk);
    total++;
    if (req1_ready !== 1) begin bad++; $display("FAIL reaccept: r1=%0b want 1", req1_ready); end
    @(posedge clk); #1 req1_valid = 0;
    repeat (5) @(posedge clk);
  endtask
  task automatic test_reset_exec;
    do_reset;
    issue(0, 4'd1, 32'd100, 32'd30, 32'd0, 32'd0);
    @(negedge clk);
    total++;
    if (alu_enable !== 1) begin bad++; $display("FAIL pre_reset_exec: en=%0b want 1", alu_enable); end
    #1 rst_n = 0;
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable, rsp0_data, rsp1_data, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus, alu_opsel} !== '0) begin
      bad++; $display("FAIL mid_reset: en=%0b s1=%0d op=%0d rsp0=%0b", alu_enable, alu_reg_s1, alu_opsel, rsp0_valid);
    end
    q.delete();
    @(posedge clk); #1;
    rst_n = 1; req0_valid = 1; req1_valid = 1;
    req0_opsel = 0; req0_s1 = 9; req0_s2 = 1;
    @(negedge clk);
    total++;
    if (req0_ready !== 1 || req1_ready !== 0 || rsp0_valid !== 0) begin
      bad++; $display("FAIL post_reset_grant: r0=%0b r1=%0b v0=%0b want 1,0,0", req0_ready, req1_ready, rsp0_valid);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (8) @(posedge clk);
  endtask
  task automatic test_code_pass;
    do_reset;
    @(negedge clk);
    total++;
    if ({alu_enable, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus, alu_opsel} !== '0) begin
      bad++; $display("FAIL idle_isolate: en=%0b code=%h op=%0d want 0", alu_enable, alu_code_bus, alu_opsel);
    end
    issue(1, 4'd14, 32'd1, 32'd2, 32'd3, 32'h12345000);
    @(negedge clk);
    total++;
    if (alu_enable !== 1 || alu_opsel !== 14 || alu_code_bus !== 32'h12345000 || alu_pc !== 3) begin
      bad++; $display("FAIL opsel_pass: en=%0b op=%0d code=%h pc=%0d want 1,14,12345000,3", alu_enable, alu_opsel, alu_code_bus, alu_pc);
    end
    @(negedge clk);
    total++;
    if (rsp1_valid !== 1 || rsp1_data !== 32'h12345000 || rsp0_valid !== 0 || rsp0_data !== 0) begin
      bad++; $display("FAIL code_rsp: v1=%0b d1=%h v0=%0b d0=%h want 1,12345000,0,0", rsp1_valid, rsp1_data, rsp0_valid, rsp0_data);
    end
    total++;
    if ({alu_enable, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus, alu_opsel} !== '0) begin
      bad++; $display("FAIL resp_isolate1: en=%0b code=%h op=%0d want 0", alu_enable, alu_code_bus, alu_opsel);
    end
    repeat (4) @(posedge clk);
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_back_pressure;
    test_reset_exec;
    test_code_pass;
    repeat (4) @(posedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL sb_drain: %0d responses outstanding want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
